angle_uart_packer: RTL and testbench
====================================

ANGLE_UART_PACKER -- requirements
Module: angle_uart_packer

Interface
REQ-001 Parameter CLK_FREQ, 50_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer, 434 at defaults) clocks per bit.
REQ-003 Parameter SEND_PERIOD, 25_000_000, clocks between packet-start ticks (0.5 s at 50 MHz).
REQ-004 clk  input  1  system clock (clk_sys50m domain); all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 x_coor  input  11  target column from the position stage.
REQ-007 y_coor  input  10  target row from the position stage.
REQ-008 coor_valid_flag  input  1  one-cycle strobe; x_coor/y_coor valid in that cycle.
REQ-009 uart_tx  output  1  8N1 serial line, idle high.
REQ-010 busy  output  1  high from tick acceptance until the last stop bit ends.
REQ-011 pkt_done  output  1  one-cycle pulse in the cycle after the last stop bit ends.

Function
REQ-012 Coordinates SHALL be captured into hold registers on every cycle coor_valid_flag=1, including while busy; a have_data flag SHALL set on the first capture and stay set until reset.
REQ-013 A free-running period counter SHALL count 0..SEND_PERIOD-1 and emit a one-cycle tick at SEND_PERIOD-1.
REQ-014 States: IDLE, CALC, SEND_START, SEND_DATA, SEND_STOP; tick in IDLE with have_data=1 -> CALC; tick in any other state, or with have_data=0, SHALL be dropped (not queued).
REQ-015 On CALC entry the hold registers SHALL be snapshotted; later captures do not affect the packet in flight.
REQ-016 angle_z SHALL equal floor(56*x/1024), computed as (x*56)>>10, 17-bit product, result fits 7 bits.
REQ-017 angle_x SHALL equal floor(40*y/720) = floor(y/18), computed by a 10-iteration restoring divider, one quotient bit per clock.
REQ-018 CALC SHALL last exactly 10 clocks; uart_tx SHALL go low (start bit of byte 0) in the 12th clock after the tick cycle.
REQ-019 Packet bytes in order: 0xAA, angle_z, angle_x, checksum (macro-dependent, REQ-026).
REQ-020 Each byte: start bit 0, 8 data bits LSB first, stop bit 1, each exactly BAUD_DIV clocks; bytes back-to-back, no idle gap.
REQ-021 After the final stop bit SHALL return to IDLE with uart_tx=1, busy=0, pkt_done=1 for one cycle.
REQ-022 coor_valid_flag and tick in the same cycle in IDLE: the new coordinate SHALL be the one snapshotted.

Reset
REQ-023 Reset assertion SHALL, asynchronously and at any point including mid-byte, force uart_tx=1, busy=0, pkt_done=0, state IDLE, have_data=0, period counter 0, hold registers 0.
REQ-024 After deassertion the first tick SHALL occur SEND_PERIOD clocks later; no packet before the first coor_valid_flag.
REQ-025 A partially sent packet SHALL NOT resume after reset.

Configuration
REQ-026 Macro ANGLE_CHECKSUM_EN defined: packet is 4 bytes, byte 3 = (0xAA + angle_z + angle_x) mod 256; undefined: packet is 3 bytes, no checksum, busy/pkt_done timing shortened by 10*BAUD_DIV clocks.

Verification
REQ-027 x=1023, y=719 valid, wait tick, macro on -> bytes 0xAA,0x37,0x27,0x08; start bit at tick+12.
REQ-028 x=2047, y=1023 -> 0xAA,0x6F,0x38,0x51 (max values, no overflow); macro off -> 0xAA,0x6F,0x38 only, pkt_done 30*434 clocks after first start bit falls.
REQ-029 No coor_valid_flag after reset, run 3 periods -> uart_tx constant 1, busy 0.
REQ-030 x=0,y=0 valid, then x=512,y=360 valid during transmission -> current packet 0xAA,0x00,0x00,0xAA; next packet 0xAA,0x1C,0x14,0xDA.
REQ-031 rst_n low in middle of byte 1 data bits -> uart_tx=1 within same cycle, busy=0; after release no output until new valid and tick.
REQ-032 Bit timing: measure every bit of one packet -> each exactly 434 clocks at defaults.

Source files
------------

// File: rtl/angle_uart_packer.sv
// rtl/angle_uart_packer.sv - periodic angle packet (0xAA, angle_z, angle_x[, checksum]) over an 8N1 UART; checksum byte enabled by `define ANGLE_CHECKSUM_EN
module angle_uart_packer #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int SEND_PERIOD = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] x_coor,
    input  logic [9:0]  y_coor,
    input  logic        coor_valid_flag,
    output logic        uart_tx,
    output logic        busy,
    output logic        pkt_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int PW       = $clog2(SEND_PERIOD + 1);
    localparam int BW       = $clog2(BAUD_DIV + 1);

`ifdef ANGLE_CHECKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd3;
`else
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

    typedef enum logic [2:0] {IDLE, CALC, SEND_START, SEND_DATA, SEND_STOP} state_t;

    state_t          state;
    logic [PW-1:0]   period_cnt;
    logic            tick;
    logic [10:0]     hold_x;
    logic [9:0]      hold_y;
    logic            have_data;
    logic [10:0]     snap_x;
    logic [9:0]      div_dvd;
    logic [4:0]      div_rem;
    logic [6:0]      quot;
    logic [3:0]      calc_cnt;
    logic [BW-1:0]   baud_cnt;
    logic            baud_end;
    logic [2:0]      bit_idx;
    logic [1:0]      byte_idx;
    logic            fin;
    logic [6:0]      angle_z;
    logic [6:0]      angle_x;
    logic [5:0]      div_trial;
    logic [5:0]      div_diff;
    logic            div_ge;
    logic [7:0]      tx_byte;
    logic            line;
`ifdef ANGLE_CHECKSUM_EN
    logic [7:0]      checksum;
`endif

    assign tick     = (period_cnt == PW'(SEND_PERIOD - 1));
    assign baud_end = (baud_cnt == BW'(BAUD_DIV - 1));

    // 56/1024 scaling of the column; the 17-bit product cannot overflow for an 11-bit x
    assign angle_z = 7'(({6'b0, snap_x} * 17'd56) >> 10);
    // quotient never exceeds 56, so only the low 7 bits of the 10-bit quotient are kept
    assign angle_x = quot;

    // one restoring-division step: shift in the next dividend bit, subtract 18 if it fits
    assign div_trial = {div_rem, div_dvd[9]};
    assign div_diff  = div_trial - 6'd18;
    assign div_ge    = (div_trial >= 6'd18);

`ifdef ANGLE_CHECKSUM_EN
    assign checksum = 8'hAA + {1'b0, angle_z} + {1'b0, angle_x};
`endif

    // select the byte currently on the wire
    always_comb begin
        tx_byte = 8'hAA;
        case (byte_idx)
            2'd1:    tx_byte = {1'b0, angle_z};
            2'd2:    tx_byte = {1'b0, angle_x};
`ifdef ANGLE_CHECKSUM_EN
            2'd3:    tx_byte = checksum;
`endif
            default: tx_byte = 8'hAA;
        endcase
    end

    // serial line level implied by the current state; registered into uart_tx one clock later
    always_comb begin
        line = 1'b1;
        case (state)
            SEND_START: line = 1'b0;
            SEND_DATA:  line = tx_byte[bit_idx];
            default:    line = 1'b1;
        endcase
    end

    // free-running packet-start period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // coordinate hold registers, refreshed on every strobe even mid-packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_x    <= '0;
            hold_y    <= '0;
            have_data <= 1'b0;
        end else if (coor_valid_flag) begin
            hold_x    <= x_coor;
            hold_y    <= y_coor;
            have_data <= 1'b1;
        end
    end

    // packet sequencer: snapshot, 10-clock divide, then serialise the bytes back-to-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            snap_x   <= '0;
            div_dvd  <= '0;
            div_rem  <= '0;
            quot     <= '0;
            calc_cnt <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            fin      <= 1'b0;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            uart_tx  <= line;
            pkt_done <= 1'b0;
            // the last stop bit leaves uart_tx one clock after the FSM reaches IDLE
            if (fin) begin
                fin      <= 1'b0;
                busy     <= 1'b0;
                pkt_done <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick && have_data) begin
                        state    <= CALC;
                        snap_x   <= coor_valid_flag ? x_coor : hold_x;
                        div_dvd  <= coor_valid_flag ? y_coor : hold_y;
                        div_rem  <= '0;
                        quot     <= '0;
                        calc_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    div_rem  <= div_ge ? div_diff[4:0] : div_trial[4:0];
                    div_dvd  <= {div_dvd[8:0], 1'b0};
                    quot     <= {quot[5:0], div_ge};
                    calc_cnt <= calc_cnt + 1'b1;
                    if (calc_cnt == 4'd9) begin
                        state    <= SEND_START;
                        baud_cnt <= '0;
                        byte_idx <= '0;
                    end
                end
                SEND_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= SEND_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                SEND_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= SEND_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                SEND_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            state <= IDLE;
                            fin   <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= SEND_START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_angle_uart_packer.sv
// tb/tb_angle_uart_packer.sv - scoreboard bench for angle_uart_packer
module tb_angle_uart_packer;

    localparam int P        = 17400;
    localparam int BD       = 434;
    localparam int BYTE_CYC = 10 * BD;
`ifdef ANGLE_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] x_coor = '0;
    logic [9:0]  y_coor = '0;
    logic        coor_valid_flag = 1'b0;
    logic        uart_tx;
    logic        busy;
    logic        pkt_done;

    angle_uart_packer #(
        .CLK_FREQ   (50_000_000),
        .BAUD       (115200),
        .SEND_PERIOD(P)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .x_coor         (x_coor),
        .y_coor         (y_coor),
        .coor_valid_flag(coor_valid_flag),
        .uart_tx        (uart_tx),
        .busy           (busy),
        .pkt_done       (pkt_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] val;
        int         start;
    } exp_byte_t;

    exp_byte_t byte_q[$];
    int        done_q[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_pkt(input int t, input logic [7:0] z, input logic [7:0] xa, input logic [7:0] ck);
        logic [7:0] b[4];
        exp_byte_t e;
        b[0] = 8'hAA; b[1] = z; b[2] = xa; b[3] = ck;
        for (int k = 0; k < NB; k++) begin
            e.val   = b[k];
            e.start = t + 12 + k * BYTE_CYC;
            byte_q.push_back(e);
        end
        done_q.push_back(t + 12 + NB * BYTE_CYC);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic strobe(input logic [10:0] x, input logic [9:0] y);
        x_coor = x; y_coor = y; coor_valid_flag = 1'b1;
        @(negedge clk);
        coor_valid_flag = 1'b0;
    endtask

    // UART byte monitor: checks value, start-bit position and the first/middle/last cycle of every bit
    initial begin : byte_monitor
        int         s;
        int         pos;
        int         j;
        logic       ok;
        logic       aborted;
        logic       have;
        logic       expv;
        logic [7:0] d;
        exp_byte_t  e;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                s = cyc; ok = 1'b1; aborted = 1'b0; d = '0;
                have = (byte_q.size() > 0);
                if (have) e = byte_q.pop_front();
                for (int c = 1; c < BYTE_CYC; c++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    pos = c % BD;
                    j   = c / BD;
                    if (j >= 1 && j <= 8 && pos == 0) d[j-1] = uart_tx;
                    if (pos == 0 || pos == BD / 2 || pos == BD - 1) begin
                        expv = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
                        if (uart_tx !== expv) ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    if (!have) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %0h at cycle %0d want none", d, s);
                    end else begin
                        check("byte_val", d, e.val);
                        check("byte_start", s, e.start);
                        check("bit_shape", int'(ok), 1);
                    end
                end
            end
        end
    end

    // pkt_done monitor: one pulse per packet at the scheduled cycle with busy already low
    initial begin : done_monitor
        forever begin
            @(negedge clk);
            if (pkt_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pkt_done: got pulse at cycle %0d want none", cyc);
                end else begin
                    check("pkt_done_cyc", cyc, done_q.pop_front());
                    check("busy_at_done", busy, 0);
                end
            end
        end
    end

    initial begin : stimulus
        int r;
        int t0;
        int t1;
        int t2;
        int r2;
        int viol;

        repeat (3) @(negedge clk);
        check("reset_tx", uart_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", pkt_done, 0);

        rst_n = 1'b1;
        r = cyc;
        t0 = r + P - 1;
        t1 = t0 + P;
        t2 = t1 + P;

        @(negedge clk);
        strobe(11'd1023, 10'd719);
        push_pkt(t0, 8'h37, 8'h27, 8'h08);

        wait_until(t0);
        check("busy_before_tick", busy, 0);
        wait_until(t0 + 2);
        check("busy_accept", busy, 1);

        wait_until(t0 + 500);
        strobe(11'd2047, 10'd1023);
        push_pkt(t1, 8'h6F, 8'h38, 8'h51);

        // strobe during CALC must not disturb the packet already snapshotted
        wait_until(t1 + 3);
        strobe(11'd5, 10'd5);

        // strobe in the tick cycle itself is the one that gets sent
        wait_until(t2);
        strobe(11'd512, 10'd360);
        push_pkt(t2, 8'h1C, 8'h14, 8'hDA);

        // reset while byte 1 data bit 0 (a zero) is on the line
        wait_until(t2 + 12 + BYTE_CYC + BD + 200);
        check("tx_low_before_reset", uart_tx, 0);
        rst_n = 1'b0;
        byte_q.delete();
        done_q.delete();
        #1;
        check("async_reset_tx", uart_tx, 1);
        check("async_reset_busy", busy, 0);
        check("async_reset_done", pkt_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r2 = cyc;

        viol = 0;
        while (cyc < r2 + P + 600) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("idle_after_reset", viol, 0);

        check("leftover_bytes", byte_q.size(), 0);
        check("leftover_done", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
